// File: rtl/cond_unit.sv
// cond_unit: condition-check and flag-storage stage.
// Holds the architectural NZCV register and evaluates each issued instruction's
// ARM-style condition field against it. The same result gates the PC, register
// and memory write strobes, and drives the executed/squashed counters.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             Illegal,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] skip_q;
  logic             cond_pass;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  // Conditions always look at the stored flags, never at this cycle's ALU flags.
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition lookup against the stored NZCV; the reserved code 1111 never passes.
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // Every strobe is qualified by valid_i so idle cycles leave no side effects.
  always_comb begin
    CondEx   = valid_i & cond_pass;
    Illegal  = valid_i & (Cond == 4'b1111);
    PCSrc    = CondEx & PCS;
    MemWrite = CondEx & MemW;
    RegWrite = CondEx & RegW & ~NoWrite;
  end

  // NZ and CV halves update independently; a squashed setter leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      if (CondEx && FlagW[1]) begin
        flags_q[3:2] <= ALUFlags[3:2];
      end
      if (CondEx && FlagW[0]) begin
        flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Each issued instruction bumps exactly one of the two wrapping counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (valid_i) begin
      if (CondEx) begin
        exec_q <= exec_q + CntOne;
      end else begin
        skip_q <= skip_q + CntOne;
      end
    end
  end

  assign Flags    = flags_q;
  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and randomized checks of cond_unit against a
// behavioural model of the condition rules, flag register and counters.
module tb_cond_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic [3:0]       Cond = 4'b0000;
  logic [3:0]       ALUFlags = 4'b0000;
  logic [1:0]       FlagW = 2'b00;
  logic             PCS = 1'b0;
  logic             RegW = 1'b0;
  logic             MemW = 1'b0;
  logic             NoWrite = 1'b0;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic             Illegal;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: stored NZCV and unbounded instruction tallies.
  logic [3:0] mf = 4'b0000;
  int         mexec = 0;
  int         mskip = 0;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Illegal  (Illegal),
    .Flags    (Flags),
    .exec_cnt (exec_cnt),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // ARM condition rule: even codes test a base predicate, odd codes invert it.
  function automatic bit refPass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    if (c == 4'd15) return 1'b0;
    case (int'(c) / 2)
      0:       base = z;
      1:       base = cy;
      2:       base = n;
      3:       base = v;
      4:       base = cy && !z;
      5:       base = (n == v);
      6:       base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (int'(c) % 2 == 1) ? !base : base;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit pass;
    pass = valid_i && refPass(Cond, mf);
    checkVal({tag, ".CondEx"},   32'(CondEx),   32'(pass));
    checkVal({tag, ".PCSrc"},    32'(PCSrc),    32'(pass && PCS));
    checkVal({tag, ".MemWrite"}, 32'(MemWrite), 32'(pass && MemW));
    checkVal({tag, ".RegWrite"}, 32'(RegWrite), 32'(pass && RegW && !NoWrite));
    checkVal({tag, ".Illegal"},  32'(Illegal),  32'(valid_i && (Cond == 4'hF)));
    checkVal({tag, ".Flags"},    32'(Flags),    32'(mf));
    checkVal({tag, ".exec_cnt"}, 32'(exec_cnt), 32'(mexec % (1 << CNT_W)));
    checkVal({tag, ".skip_cnt"}, 32'(skip_cnt), 32'(mskip % (1 << CNT_W)));
  endtask

  // Drive one instruction, check the combinational view, then commit it at the edge.
  task automatic applyStimulus(input bit v, input logic [3:0] c, input logic [3:0] a,
                               input logic [1:0] fw, input bit p, input bit rw,
                               input bit mw, input bit nw, input string tag);
    bit pass;
    valid_i  = v;
    Cond     = c;
    ALUFlags = a;
    FlagW    = fw;
    PCS      = p;
    RegW     = rw;
    MemW     = mw;
    NoWrite  = nw;
    #1;
    checkOutput(tag);
    pass = v && refPass(c, mf);
    @(posedge clk);
    if (v) begin
      if (pass) mexec++;
      else      mskip++;
      if (pass && fw[1]) mf[3:2] = a[3:2];
      if (pass && fw[0]) mf[1:0] = a[1:0];
    end
    #1;
  endtask

  task automatic idleInputs();
    valid_i  = 1'b0;
    Cond     = 4'b0000;
    ALUFlags = 4'b0000;
    FlagW    = 2'b00;
    PCS      = 1'b0;
    RegW     = 1'b0;
    MemW     = 1'b0;
    NoWrite  = 1'b0;
  endtask

  // Reset held across an edge; any instruction on the inputs is dropped.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    mf    = 4'b0000;
    mexec = 0;
    mskip = 0;
    @(posedge clk);
    #1;
    checkVal({tag, ".Flags"},    32'(Flags),    32'h0);
    checkVal({tag, ".exec_cnt"}, 32'(exec_cnt), 32'h0);
    checkVal({tag, ".skip_cnt"}, 32'(skip_cnt), 32'h0);
    idleInputs();
    #1;
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idleInputs();
    doReset("reset");

    // Flags=0 after reset: EQ squashed, NE executes.
    applyStimulus(1, 4'b0000, 4'h0, 2'b00, 0, 1, 0, 0, "eq_after_reset");
    checkVal("eq_after_reset.skip_cnt", 32'(skip_cnt), 32'd1);
    applyStimulus(1, 4'b0001, 4'h0, 2'b00, 0, 1, 0, 0, "ne_after_reset");
    checkVal("ne_after_reset.exec_cnt", 32'(exec_cnt), 32'd1);

    // Set Z, then EQ memory write in the very next cycle.
    applyStimulus(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, "set_z");
    checkVal("set_z.Flags", 32'(Flags), 32'h4);
    valid_i = 1'b1; Cond = 4'b0000; MemW = 1'b1; FlagW = 2'b00;
    #1;
    checkVal("eq_after_set.MemWrite", 32'(MemWrite), 32'd1);
    applyStimulus(1, 4'b0000, 4'h0, 2'b00, 0, 0, 1, 0, "eq_after_set");

    // Split write touches only C and V.
    applyStimulus(1, 4'b1110, 4'hF, 2'b11, 0, 0, 0, 0, "set_all");
    checkVal("set_all.Flags", 32'(Flags), 32'hF);
    applyStimulus(1, 4'b1110, 4'h0, 2'b01, 0, 0, 0, 0, "split_cv");
    checkVal("split_cv.Flags", 32'(Flags), 32'hC);

    // Squashed flag setter leaves the register alone.
    applyStimulus(1, 4'b1110, 4'h0, 2'b11, 0, 0, 0, 0, "clear_all");
    applyStimulus(1, 4'b0000, 4'hF, 2'b11, 0, 1, 0, 0, "squash_setter");
    checkVal("squash_setter.Flags", 32'(Flags), 32'h0);

    // Compare-class instruction: no register write but flags still move.
    applyStimulus(1, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 1, "nowrite");
    checkVal("nowrite.Flags", 32'(Flags), 32'hA);

    // Reserved code: illegal only while issued.
    applyStimulus(0, 4'b1111, 4'h0, 2'b00, 1, 1, 1, 0, "reserved_idle");
    applyStimulus(1, 4'b1111, 4'h5, 2'b11, 1, 1, 1, 0, "reserved_valid");

    // Every condition against every flag combination.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, $sformatf("sweep_set_f%0d", f));
        applyStimulus(1, 4'(c), 4'h0, 2'b00, 1, 1, 1, 0, $sformatf("sweep_f%0d_c%0d", f, c));
      end
    end

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(3) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $sformatf("rand_%0d", i));
    end

    // Counter wrap: 17 executed instructions on a 4-bit counter.
    doReset("reset_wrap");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, "wrap");
    end
    checkVal("wrap.exec_cnt", 32'(exec_cnt), 32'd1);

    // Reset held across an edge drops the flag-setting instruction in flight.
    valid_i = 1'b1; Cond = 4'b1110; ALUFlags = 4'hF; FlagW = 2'b11;
    doReset("reset_mid_instr");

    // Asynchronous pulse while clk is low clears state before the next edge.
    applyStimulus(1, 4'b1110, 4'h9, 2'b11, 0, 0, 0, 0, "pre_pulse_set");
    applyStimulus(1, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0, "pre_pulse_skip");
    idleInputs();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    mf    = 4'b0000;
    mexec = 0;
    mskip = 0;
    checkVal("async_pulse.Flags",    32'(Flags),    32'h0);
    checkVal("async_pulse.exec_cnt", 32'(exec_cnt), 32'h0);
    checkVal("async_pulse.skip_cnt", 32'(skip_cnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 4'b0001, 4'h0, 2'b00, 0, 1, 0, 0, "after_pulse_ne");
    checkOutput("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
